i2c_reg_master: RTL and testbench

- I2C controller (initiator) that performs single-register writes and reads against an I2C register-bank target over the board's two-wire bus.
- Pairs with the existing I2C target interface and register bank: bench stimulus, loop-back self-test and on-board configuration of a second device.
- Accepts one command at a time through a valid/ready port. Drives SCL/SDA as open-drain enables and returns read data and ACK status through a one-cycle response pulse.

---
 rtl/i2c_reg_master.sv | 163 ++++++++++++++++
 tb/tb_i2c_reg_master.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_master.sv
// Single-register I2C controller: write {dev,0} addr data, or read via repeated START.
// SCL/SDA are open-drain enables; each bus phase is four CLK_DIV-cycle quarters.
module i2c_reg_master #(
    parameter int unsigned CLK_DIV  = 30,
    parameter logic [6:0]  DEV_ADDR = 7'h3C
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in
);

    typedef enum logic [2:0] {
        StIdle, StStart, StByte, StAck, StRestart, StStop, StDone
    } state_e;

    state_e     state_q, state_d;
    logic [9:0] qcnt_q;
    logic [1:0] quarter_q;
    logic [2:0] bit_q;
    logic [1:0] byte_q;
    logic       rw_q;
    logic [7:0] addr_q, wdata_q, shift_q, rdata_q;
    logic       nack_q, rsp_nack_q;
    logic       scl_q, sda_q, scl_d, sda_d;
    logic [1:0] sync_q;
    logic       sda_s, accept, qtick, q2_end, q3_end, tx_bit, mid_clk;
    logic [7:0] tx_byte;

    assign accept    = cmd_valid && (state_q == StIdle);
    assign qtick     = (state_q != StIdle) && (qcnt_q == 10'(CLK_DIV - 1));
    assign q2_end    = qtick && (quarter_q == 2'd2);
    assign q3_end    = qtick && (quarter_q == 2'd3);
    assign sda_s     = sync_q[1];
    assign mid_clk   = (quarter_q == 2'd0) || (quarter_q == 2'd3);
    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign rsp_valid = (state_q == StDone);
    assign rsp_rdata = rdata_q;
    assign rsp_nack  = rsp_nack_q;
    assign scl_oe    = scl_q;
    assign sda_oe    = sda_q;

    // Byte 2 is the write data for writes and the read-direction address for reads.
    always_comb begin
        tx_byte = 8'hFF;
        unique case (byte_q)
            2'd0: tx_byte = {DEV_ADDR, 1'b0};
            2'd1: tx_byte = addr_q;
            2'd2: tx_byte = rw_q ? {DEV_ADDR, 1'b1} : wdata_q;
            2'd3: tx_byte = 8'hFF;
        endcase
    end

    assign tx_bit = tx_byte[3'd7 - bit_q];

    always_comb begin
        state_d = state_q;
        scl_d   = 1'b0;
        sda_d   = 1'b0;
        unique case (state_q)
            StIdle: if (cmd_valid) state_d = StStart;
            StStart: begin
                sda_d = (quarter_q >= 2'd2);
                scl_d = (quarter_q == 2'd3);
                if (q3_end) state_d = StByte;
            end
            StByte: begin
                scl_d = mid_clk;
                sda_d = ~tx_bit;
                if (q3_end && bit_q == 3'd7) state_d = StAck;
            end
            StAck: begin
                scl_d = mid_clk;
                if (q3_end) begin
                    if (nack_q || byte_q == 2'd3 || (byte_q == 2'd2 && !rw_q)) begin
                        state_d = StStop;
                    end else if (byte_q == 2'd1 && rw_q) begin
                        state_d = StRestart;
                    end else begin
                        state_d = StByte;
                    end
                end
            end
            StRestart: begin
                scl_d = mid_clk;
                sda_d = (quarter_q >= 2'd2);
                if (q3_end) state_d = StByte;
            end
            StStop: begin
                scl_d = (quarter_q == 2'd0);
                sda_d = (quarter_q <= 2'd1);
                if (q3_end) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            qcnt_q     <= '0;
            quarter_q  <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            shift_q    <= '0;
            rdata_q    <= '0;
            nack_q     <= 1'b0;
            rsp_nack_q <= 1'b0;
            scl_q      <= 1'b0;
            sda_q      <= 1'b0;
            sync_q     <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], sda_in};
            scl_q  <= scl_d;
            sda_q  <= sda_d;
            if (accept) begin
                rw_q      <= cmd_rw;
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                nack_q    <= 1'b0;
                bit_q     <= '0;
                byte_q    <= '0;
                qcnt_q    <= '0;
                quarter_q <= '0;
            end else if (state_q == StIdle || state_q == StDone) begin
                qcnt_q    <= '0;
                quarter_q <= '0;
            end else begin
                qcnt_q <= qtick ? 10'd0 : qcnt_q + 10'd1;
                if (qtick) quarter_q <= quarter_q + 2'd1;
                if (q2_end && state_q == StByte) shift_q <= {shift_q[6:0], sda_s};
                // Byte 3's ACK slot is our own NACK to the target, not a status bit.
                if (q2_end && state_q == StAck && byte_q != 2'd3 && sda_s) nack_q <= 1'b1;
                if (q3_end && state_q == StByte) bit_q <= bit_q + 3'd1;
                if (q3_end && state_q == StAck) byte_q <= byte_q + 2'd1;
                if (q3_end && state_q == StStop) begin
                    rsp_nack_q <= nack_q;
                    rdata_q    <= (rw_q && !nack_q) ? shift_q : 8'h00;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_master.sv
// Bench for i2c_reg_master: behavioural I2C register target on the wired-AND bus,
// transaction-level reference model for responses, latency and bus byte sequence.
module tb_i2c_reg_master;

    localparam int unsigned CLK_DIV = 4;
    localparam logic [6:0]  DEV     = 7'h3C;

    logic       clk = 1'b0;
    logic       resetb;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_nack, busy, scl_oe, sda_oe, sda_in;
    logic [7:0] rsp_rdata;
    logic       scl_line, sda_line;
    logic       tgt_pull = 1'b0;
    bit         present = 1'b1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // Target/monitor state, written only by the target process.
    int         n_start = 0, n_stop = 0, n_rsp = 0, viol = 0, blog_n = 0;
    logic [8:0] blog [0:255];
    logic [7:0] wmem [0:255];
    bit         written [0:255];
    bit         mack = 1'b0;

    // Reference model contents.
    logic [7:0] ref_mem [0:255];
    bit         ref_wr [0:255];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign scl_line = ~scl_oe;
    assign sda_line = ~(sda_oe | tgt_pull);
    assign sda_in   = sda_line;

    i2c_reg_master #(.CLK_DIV(CLK_DIV), .DEV_ADDR(DEV)) dut (
        .clk(clk), .resetb(resetb), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .busy(busy),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in)
    );

    // Behavioural register-bank target; unwritten registers read as addr ^ 0x48.
    initial begin
        bit scl_p = 1'b1, sda_p = 1'b1, scl, sda;
        bit in_xfer = 1'b0, addressed = 1'b0, rd = 1'b0, tx = 1'b0;
        int bitcnt = 0, byte_idx = 0;
        logic [7:0] shreg = 8'h00, txdata = 8'h00, reg_ptr = 8'h00;
        forever begin
            @(negedge clk);
            if (!resetb) begin
                in_xfer = 1'b0; tx = 1'b0; tgt_pull = 1'b0; bitcnt = 0;
                scl_p = 1'b1; sda_p = 1'b1;
            end else begin
                scl = scl_line;
                sda = sda_line;
                if (busy !== ~cmd_ready) viol++;
                if (rsp_valid) n_rsp++;
                if (scl_p && scl && sda_p && !sda) begin
                    n_start++;
                    in_xfer = 1'b1; bitcnt = 0; byte_idx = 0; tx = 1'b0; addressed = 1'b0;
                    blog[blog_n % 256] = 9'h100;
                    blog_n++;
                end else if (scl_p && scl && !sda_p && sda) begin
                    n_stop++;
                    in_xfer = 1'b0; tx = 1'b0;
                end else if (in_xfer && !scl_p && scl) begin
                    bitcnt++;
                    if (bitcnt <= 8) shreg = {shreg[6:0], sda};
                    else if (tx) mack = sda;
                end else if (in_xfer && scl_p && !scl) begin
                    if (bitcnt == 8) begin
                        blog[blog_n % 256] = {1'b0, shreg};
                        blog_n++;
                        if (tx) begin
                            tgt_pull = 1'b0;
                        end else begin
                            if (byte_idx == 0) begin
                                addressed = present && (shreg[7:1] == DEV);
                                rd = shreg[0];
                            end else if (addressed && !rd) begin
                                if (byte_idx == 1) begin
                                    reg_ptr = shreg;
                                end else begin
                                    wmem[reg_ptr] = shreg;
                                    written[reg_ptr] = 1'b1;
                                    reg_ptr++;
                                end
                            end
                            tgt_pull = addressed;
                        end
                    end else if (bitcnt == 9) begin
                        tgt_pull = 1'b0;
                        bitcnt = 0;
                        if (addressed && rd && byte_idx == 0) begin
                            tx = 1'b1;
                            txdata = written[reg_ptr] ? wmem[reg_ptr] : (reg_ptr ^ 8'h48);
                            tgt_pull = ~txdata[7];
                        end else begin
                            tx = 1'b0;
                        end
                        byte_idx++;
                    end else if (tx && bitcnt >= 1 && bitcnt <= 7) begin
                        tgt_pull = ~txdata[7 - bitcnt];
                    end
                end
                scl_p = scl;
                sda_p = sda;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_read(input logic [7:0] a);
        return ref_wr[a] ? ref_mem[a] : (a ^ 8'h48);
    endfunction

    // Bus time in quarters: START + 9-quarter-slot bytes + optional RESTART + STOP.
    function automatic int exp_latency(input logic rw, input bit pres);
        int nbytes, quarters;
        nbytes   = !pres ? 1 : (rw ? 4 : 3);
        quarters = 4 + nbytes * 9 * 4 + ((rw && pres) ? 4 : 0) + 4;
        return quarters * CLK_DIV + 1;
    endfunction

    task automatic wait_rsp_and_check(input int acc, input logic rw, input logic [7:0] a,
                                      input logic [7:0] d, input bit pres);
        int         k;
        logic [7:0] exp_rd;
        exp_rd = (rw && pres) ? ref_read(a) : 8'h00;
        if (!rw && pres) begin
            ref_mem[a] = d;
            ref_wr[a]  = 1'b1;
        end
        k = 0;
        while (!rsp_valid && k < 200 * CLK_DIV) begin
            @(negedge clk);
            k++;
        end
        check("rsp_valid_seen", rsp_valid, 1);
        check("rsp_latency", cyc - acc, exp_latency(rw, pres));
        check("rsp_nack", rsp_nack, !pres);
        check("rsp_rdata", rsp_rdata, exp_rd);
        @(negedge clk);
        check("rsp_single_pulse", rsp_valid, 0);
        check("rdata_held", rsp_rdata, exp_rd);
        check("ready_after_done", {busy, cmd_ready}, 2'b01);
    endtask

    task automatic issue(input logic rw, input logic [7:0] a, input logic [7:0] d, input bit pres);
        int         acc, k, s0, p0, b0, r0, exp_n;
        logic [8:0] exp_log [0:5];
        present = pres;
        @(negedge clk);
        s0 = n_start; p0 = n_stop; b0 = blog_n; r0 = n_rsp;
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d;
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("cmd_ready_for_accept", cmd_ready, 1);
        acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_rw    = 1'($urandom);
        cmd_addr  = 8'($urandom);
        cmd_wdata = 8'($urandom);
        check("busy_after_accept", {busy, cmd_ready}, 2'b10);
        exp_log[0] = 9'h100;
        exp_log[1] = {1'b0, DEV, 1'b0};
        exp_n = 2;
        if (pres) begin
            exp_log[2] = {1'b0, a};
            if (rw) begin
                exp_log[3] = 9'h100;
                exp_log[4] = {1'b0, DEV, 1'b1};
                exp_log[5] = {1'b0, ref_read(a)};
                exp_n = 6;
            end else begin
                exp_log[3] = {1'b0, d};
                exp_n = 4;
            end
        end
        wait_rsp_and_check(acc, rw, a, d, pres);
        check("rsp_count", n_rsp - r0, 1);
        check("start_count", n_start - s0, (rw && pres) ? 2 : 1);
        check("stop_count", n_stop - p0, 1);
        check("bus_log_len", blog_n - b0, exp_n);
        for (int i = 0; i < exp_n; i++) begin
            if (i < blog_n - b0) check("bus_byte", blog[(b0 + i) % 256], exp_log[i]);
        end
        if (rw && pres) check("master_nack_on_read", mack, 1);
        check("protocol", viol, 0);
    endtask

    initial begin
        int         acc, k, r0, s0;
        logic       b_rw [0:2];
        logic [7:0] b_a [0:2];
        logic [7:0] b_d [0:2];
        logic       rrw;
        logic [7:0] ra, rd8;
        bit         rp;

        resetb = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_ready", {cmd_ready, busy, rsp_valid}, 3'b100);
        check("reset_rsp", {rsp_nack, rsp_rdata}, 9'h000);
        check("reset_lines", {scl_oe, sda_oe}, 2'b00);
        resetb = 1'b1;
        repeat (3) @(negedge clk);

        // Directed: read before any write returns the target default (0x5A at 0x12).
        issue(1'b1, 8'h12, 8'h00, 1'b1);
        check("read_default_5a", rsp_rdata, 8'h5A);
        issue(1'b0, 8'h12, 8'hA5, 1'b1);
        issue(1'b1, 8'h12, 8'h00, 1'b1);
        issue(1'b0, 8'h20, 8'h00, 1'b1);
        issue(1'b0, 8'h21, 8'hFF, 1'b1);
        issue(1'b0, 8'h22, 8'h66, 1'b0);
        issue(1'b1, 8'h21, 8'h00, 1'b0);

        // Back-to-back with cmd_valid held high.
        b_rw[0] = 1'b0; b_a[0] = 8'h30; b_d[0] = 8'h11;
        b_rw[1] = 1'b1; b_a[1] = 8'h30; b_d[1] = 8'hEE;
        b_rw[2] = 1'b0; b_a[2] = 8'h31; b_d[2] = 8'h22;
        present = 1'b1;
        @(negedge clk);
        r0 = n_rsp; s0 = n_start;
        cmd_valid = 1'b1; cmd_rw = b_rw[0]; cmd_addr = b_a[0]; cmd_wdata = b_d[0];
        for (int i = 0; i < 3; i++) begin
            k = 0;
            while (!cmd_ready && k < 100) begin
                @(negedge clk);
                k++;
            end
            check("b2b_ready", cmd_ready, 1);
            check("b2b_no_overlap", n_rsp - r0, i);
            acc = cyc;
            @(negedge clk);
            if (i < 2) begin
                cmd_rw = b_rw[i + 1]; cmd_addr = b_a[i + 1]; cmd_wdata = b_d[i + 1];
            end else begin
                cmd_valid = 1'b0;
            end
            wait_rsp_and_check(acc, b_rw[i], b_a[i], b_d[i], 1'b1);
        end
        repeat (2) @(negedge clk);
        check("b2b_rsp_pulses", n_rsp - r0, 3);
        check("b2b_starts", n_start - s0, 4);
        check("b2b_protocol", viol, 0);

        // Reset during the second byte of a read, while both lines are pulled low.
        present = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 8'h12; cmd_wdata = 8'h00;
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (cyc < acc + 1 + 48 * CLK_DIV + 2 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("pre_reset_busy", busy, 1);
        check("pre_reset_lines", {scl_oe, sda_oe}, 2'b11);
        resetb = 1'b0;
        #1;
        check("reset_mid_lines", {scl_oe, sda_oe}, 2'b00);
        check("reset_mid_ready", {cmd_ready, busy, rsp_valid}, 3'b100);
        repeat (2) @(negedge clk);
        resetb = 1'b1;
        repeat (2) @(negedge clk);
        issue(1'b0, 8'h44, 8'h3C, 1'b1);
        issue(1'b1, 8'h44, 8'h00, 1'b1);

        // Randomized commands against the reference model.
        for (int n = 0; n < 12; n++) begin
            rrw = 1'($urandom_range(0, 1));
            ra  = 8'($urandom_range(32, 39));
            rd8 = 8'($urandom);
            rp  = ($urandom_range(0, 7) != 0);
            issue(rrw, ra, rd8, rp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
